// File: rtl/stream_sel_arbiter_if.sv
// Handshake bundle between two packet streams, the downstream sink and the
// stream select arbiter.
interface stream_sel_arbiter_if;
  logic req_0;
  logic last_0;
  logic req_1;
  logic last_1;
  logic out_ready;
  logic sel;
  logic grant_0;
  logic grant_1;
  logic out_valid;
  logic out_last;
  logic in_ready_0;
  logic in_ready_1;
  logic forced;

  modport slave (
    input  req_0, last_0, req_1, last_1, out_ready,
    output sel, grant_0, grant_1, out_valid, out_last,
    output in_ready_0, in_ready_1, forced
  );

  modport master (
    output req_0, last_0, req_1, last_1, out_ready,
    input  sel, grant_0, grant_1, out_valid, out_last,
    input  in_ready_0, in_ready_1, forced
  );
endinterface

// File: rtl/stream_sel_arbiter.sv
// Round-robin packet arbiter for two valid/ready streams; holds the grant for
// a whole packet and drives the select of the downstream 2:1 data mux.
module stream_sel_arbiter #(
  parameter int MAX_BEATS = 0,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_sel_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic             LIMIT_EN = (MAX_BEATS > 0);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  state_t           state, state_nxt;
  logic             sel_q, sel_nxt;
  logic             grant_0_q, grant_0_nxt;
  logic             grant_1_q, grant_1_nxt;
  logic             forced_q, forced_nxt;
  logic             prio, prio_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic req_s, last_s, at_limit, xfer, pick;
  logic out_valid, out_last, in_ready_0, in_ready_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      grant_0_q <= 1'b0;
      grant_1_q <= 1'b0;
      forced_q  <= 1'b0;
      prio      <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      sel_q     <= sel_nxt;
      grant_0_q <= grant_0_nxt;
      grant_1_q <= grant_1_nxt;
      forced_q  <= forced_nxt;
      prio      <= prio_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel_q;
    grant_0_nxt = grant_0_q;
    grant_1_nxt = grant_1_q;
    forced_nxt  = 1'b0;
    prio_nxt    = prio;
    cnt_nxt     = cnt;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    in_ready_0  = 1'b0;
    in_ready_1  = 1'b0;
    xfer        = 1'b0;
    pick        = 1'b0;
    req_s       = sel_q ? bus.req_1  : bus.req_0;
    last_s      = sel_q ? bus.last_1 : bus.last_0;
    at_limit    = LIMIT_EN && (cnt == LIMIT);

    case (state)
      IDLE: begin
        // sel only moves here, so the mux output stays put between packets
        if (bus.req_0 || bus.req_1) begin
          pick        = (bus.req_0 && bus.req_1) ? prio : bus.req_1;
          state_nxt   = LOCKED;
          sel_nxt     = pick;
          grant_0_nxt = ~pick;
          grant_1_nxt = pick;
          cnt_nxt     = '0;
        end
      end
      LOCKED: begin
        out_valid  = req_s;
        out_last   = last_s | at_limit;
        in_ready_0 = ~sel_q & bus.out_ready;
        in_ready_1 = sel_q & bus.out_ready;
        xfer       = req_s & bus.out_ready;
        if (xfer) begin
          cnt_nxt = cnt + 1'b1;
          if (last_s || at_limit) begin
            state_nxt   = IDLE;
            grant_0_nxt = 1'b0;
            grant_1_nxt = 1'b0;
            cnt_nxt     = '0;
            prio_nxt    = ~sel_q;
            forced_nxt  = at_limit & ~last_s;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sel        = sel_q;
  assign bus.grant_0    = grant_0_q;
  assign bus.grant_1    = grant_1_q;
  assign bus.forced     = forced_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_last   = out_last;
  assign bus.in_ready_0 = in_ready_0;
  assign bus.in_ready_1 = in_ready_1;

endmodule

// File: doc/stream_sel_arbiter.md
Name: stream_sel_arbiter

Overview:
- Upstream control stage for the 2:1 data mux (`mux`, ports din_0/din_1/sel/mux_out).
- Arbitrates between two valid/ready packet streams and drives the mux select.
- Holds the grant for a whole packet, delimited by last. Alternates fairly between the two inputs (round-robin).
- Data buses are not routed through this block. One `mux` instance per data bit consumes sel.

Parameters:
- MAX_BEATS, 0: beats after which a packet is forcibly released; 0 = unlimited.
- CNT_W, 8: width of the beat counter; MAX_BEATS must be < 2^CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_0  input  1  stream 0 valid.
- last_0  input  1  stream 0 last beat of packet.
- req_1  input  1  stream 1 valid.
- last_1  input  1  stream 1 last beat of packet.
- out_ready  input  1  downstream ready.
- sel  output  1  mux select; 0 = stream 0, 1 = stream 1. Registered.
- grant_0  output  1  stream 0 owns the output. Registered.
- grant_1  output  1  stream 1 owns the output. Registered.
- out_valid  output  1  valid toward downstream.
- out_last  output  1  last toward downstream.
- in_ready_0  output  1  ready back to stream 0.
- in_ready_1  output  1  ready back to stream 1.
- forced  output  1  one-cycle pulse: packet released by MAX_BEATS.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, sel=0, grant_0=0, grant_1=0, beat counter=0, forced=0.
  - Priority pointer prio=0, so stream 0 wins the first tie.
  - Combinational outputs evaluate to 0.
- Reset mid-packet aborts the packet with no further handshakes. Release is synchronous to clk.
- State IDLE:
  - out_valid=0, in_ready_0=0, in_ready_1=0.
  - If only req_x is high, the next state is LOCKED with sel=x and grant_x=1.
  - If both are high, prio decides: x=prio.
  - If neither is high, stay in IDLE.
  - Arbitration costs exactly one bubble cycle: a request first sampled in IDLE sees the grant on the next cycle.
- State LOCKED (selected stream s = sel):
  - out_valid = req_s.
  - out_last = last_s, or the counter reaching MAX_BEATS-1 (when MAX_BEATS>0).
  - in_ready_s = out_ready. The other stream's in_ready = 0.
  - Transfer = out_valid & out_ready. Each transfer increments the counter.
  - req_s dropping mid-packet keeps the lock; out_valid=0, and the other stream is not granted.
  - Release when a transfer occurs with last_s=1, or when MAX_BEATS>0 and the counter equals MAX_BEATS-1:
    - Next state IDLE, grants cleared, counter cleared, prio = ~s.
    - sel holds its value in IDLE, so the mux output stays stable.
  - A forced release (counter limit without last_s) pulses forced=1 for the cycle after the transfer.
  - The stream is expected to continue its packet when it is next granted.
- Simultaneous events: req/last changes of the non-selected stream during LOCKED have no effect.
- Counter: saturates never. Width CNT_W, wraps only if MAX_BEATS=0 (no significance then).
- No combinational path from req_x to sel; sel changes only on the clk edge entering LOCKED.

Test Plan:
- Single stream, 3-beat packet:
  - Stimulus: reset, then req_0=1 constantly, last_0 on the 3rd beat, out_ready=1.
  - Response: grant_0 after 1 bubble cycle, 3 transfers, sel=0.
  - Then IDLE one cycle, prio=1, forced=0.
- Tie and alternation:
  - Stimulus: req_0=req_1=1 continuously, each sending 2-beat packets.
  - Response: grant order 0,1,0,1.
  - sel toggles only on IDLE→LOCKED edges, with one bubble cycle between packets.
- Backpressure:
  - Stimulus: locked on stream 1, out_ready toggles 1,0,1,0.
  - Response: in_ready_1 mirrors out_ready, in_ready_0=0 throughout.
  - The counter advances only on transfers.
- Valid gap:
  - Stimulus: locked on stream 0, req_0 drops for 4 cycles while req_1=1.
  - Response: the lock holds, out_valid=0, grant_1 never asserts until last_0 transfers.
- MAX_BEATS=4:
  - Stimulus: stream 0 sends 10 beats without last.
  - Response: release after beat 4, with out_last=1 on beat 4 and a forced pulse.
  - Stream 1 (requesting) is granted next.
- Async reset mid-packet:
  - Stimulus: rst_n low between clock edges during beat 2.
  - Response: grants, out_valid, in_ready and sel go to 0 immediately, without waiting for a clock edge.
  - After release, the first tie goes to stream 0.
